jt89_mixer_cic: RTL

JT89_MIXER_CIC -- requirements
Module: jt89_mixer_cic

---
 rtl/jt89_mixer_cic_pkg.sv | 26 ++
 rtl/jt89_mix_sum.sv | 31 +++
 rtl/jt89_mixer_cic.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jt89_mixer_cic_pkg.sv
// Shared definitions for the jt89 CIC mixer: default widths, unity gain,
// ceiling-log2 helper and the output saturation classification.
package jt89_mixer_cic_pkg;

  localparam int unsigned DEF_BW     = 9;
  localparam int unsigned DEF_GW     = 4;
  localparam int unsigned UNITY_GAIN = 1 << (DEF_GW - 1);

  // Outcome of clamping the scaled integrator output into the unsigned range.
  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_LOW,
    SAT_HIGH
  } sat_e;

  // Ceiling log2; clog2(1) is 0 so a single channel adds no headroom bits.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jt89_mix_sum.sv
// Combinational gain multiply and adder tree: sum of ch_k*gain_k, scaled
// down so that a gain of 2^(GW-1) passes a channel at unity.
module jt89_mix_sum
  import jt89_mixer_cic_pkg::*;
#(
  parameter int unsigned BW = DEF_BW,
  parameter int unsigned CH = 4,
  parameter int unsigned GW = DEF_GW,
  localparam int unsigned SW = BW + 1 + clog2(CH)
) (
  input  logic [CH*BW-1:0] ch,
  input  logic [CH*GW-1:0] gain,
  output logic [SW-1:0]    mix
);

  // Full-precision accumulator; the scaled result always fits in SW bits.
  localparam int unsigned PW = BW + GW + clog2(CH);

  logic [PW-1:0] acc;

  // Accumulate every channel's gained sample at full precision.
  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      acc = acc + PW'(ch[k*BW +: BW]) * PW'(gain[k*GW +: GW]);
    end
  end

  assign mix = SW'(acc >> (GW - 1));

endmodule

// File: rtl/jt89_mixer_cic.sv
// Channel mixer followed by a CIC interpolator. The mix is sampled once
// every 2^RATE_LOG2 clk_en, differentiated at the low rate, zero-stuffed,
// integrated at the output rate and clamped to an unsigned sample.
module jt89_mixer_cic
  import jt89_mixer_cic_pkg::*;
#(
  parameter int unsigned BW        = DEF_BW,
  parameter int unsigned CH        = 4,
  parameter int unsigned RATE_LOG2 = 4,
  parameter int unsigned ORDER     = 2,
  parameter int unsigned GW        = DEF_GW,
  localparam int unsigned SW = BW + 1 + clog2(CH),
  localparam int unsigned FW = SW + ORDER * RATE_LOG2 + 1,
  localparam int unsigned OW = SW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [CH*BW-1:0] ch,
  input  logic [CH*GW-1:0] gain,
  input  logic             clip_clr,
  output logic             in_cen,
  output logic [OW-1:0]    sound,
  output logic             clip
);

  // Removes the R^(ORDER-1) gain of the zero-stuffed CIC.
  localparam int unsigned SHIFT = RATE_LOG2 * (ORDER - 1);

  logic [RATE_LOG2-1:0] phase;
  logic                 strobe;
  logic [SW-1:0]        mix_now;
  logic [SW-1:0]        mix_r;
  logic signed [FW-1:0] mix_ext;
  logic signed [FW-1:0] comb_out;
  logic signed [FW-1:0] interp;
  logic signed [FW-1:0] integ_out;
  logic signed [FW-1:0] y;
  logic [OW-1:0]        sound_next;
  sat_e                 sat;

  assign strobe = clk_en && (phase == '0);
  assign in_cen = strobe;

  jt89_mix_sum #(
    .BW(BW),
    .CH(CH),
    .GW(GW)
  ) u_mix (
    .ch  (ch),
    .gain(gain),
    .mix (mix_now)
  );

  // Output-rate phase counter; wraps every 2^RATE_LOG2 clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (clk_en) begin
      phase <= phase + RATE_LOG2'(1);
    end
  end

  // Capture the mix only on the input strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_r <= '0;
    end else if (strobe) begin
      mix_r <= mix_now;
    end
  end

  assign mix_ext = signed'(FW'(mix_r));

  // Low-rate comb chain: each stage outputs the difference of its input
  // against the value that input had on the previous strobe.
  for (genvar j = 0; j < ORDER; j++) begin : g_comb
    logic signed [FW-1:0] din;
    logic signed [FW-1:0] dly;
    logic signed [FW-1:0] q;

    if (j == 0) begin : g_first
      assign din = mix_ext;
    end else begin : g_next
      assign din = g_comb[j-1].q;
    end

    // Differentiate once per strobe.
    always_ff @(posedge clk) begin
      if (rst) begin
        dly <= '0;
        q   <= '0;
      end else if (strobe) begin
        dly <= din;
        q   <= din - dly;
      end
    end
  end

  assign comb_out = g_comb[ORDER-1].q;

  // Zero-stuff the comb output up to the clk_en rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      interp <= '0;
    end else if (clk_en) begin
      interp <= strobe ? comb_out : '0;
    end
  end

  // Output-rate integrators; two's-complement wrap cancels against the combs.
  for (genvar j = 0; j < ORDER; j++) begin : g_integ
    logic signed [FW-1:0] din;
    logic signed [FW-1:0] acc;

    if (j == 0) begin : g_first
      assign din = interp;
    end else begin : g_next
      assign din = g_integ[j-1].acc;
    end

    // Accumulate once per clk_en.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
      end else if (clk_en) begin
        acc <= acc + din;
      end
    end
  end

  assign integ_out = g_integ[ORDER-1].acc;
  assign y         = integ_out >>> SHIFT;

  // Clamp the scaled integrator output into the unsigned output range.
  always_comb begin
    sat        = SAT_NONE;
    sound_next = y[OW-1:0];
    if (y[FW-1]) begin
      sat        = SAT_LOW;
      sound_next = '0;
    end else if (y[FW-2:OW] != '0) begin
      sat        = SAT_HIGH;
      sound_next = '1;
    end
  end

  // Register the clamped sample at the output rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sound <= '0;
    end else if (clk_en) begin
      sound <= sound_next;
    end
  end

  // Sticky clip flag; a saturating clk_en outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip <= 1'b0;
    end else if (clk_en && (sat != SAT_NONE)) begin
      clip <= 1'b1;
    end else if (clip_clr) begin
      clip <= 1'b0;
    end
  end

endmodule
